// File: rtl/nios2_cordic_ctrl_if.sv
// nios2_cordic_ctrl_if: Avalon-MM slave bus for the CORDIC controller (zero wait states, combinational readdata).
interface nios2_cordic_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, read, write, writedata, input readdata);
    modport slave  (input address, chipselect, read, write, writedata, output readdata);
endinterface

// File: rtl/nios2_cordic_ctrl.sv
// nios2_cordic_ctrl: register file and sequencer driving an iterative CORDIC datapath (load, N steps, capture).
module nios2_cordic_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ITERATIONS = 16,
    parameter int ITER_W     = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    nios2_cordic_ctrl_if.slave    bus,
    output logic                  irq,
    output logic                  dp_load,
    output logic [DATA_W-1:0]     dp_angle,
    output logic                  dp_step,
    output logic [ITER_W-1:0]     dp_iter,
    input  logic [DATA_W-1:0]     dp_x,
    input  logic [DATA_W-1:0]     dp_y
);
    typedef enum logic [1:0] {IDLE, LOAD, STEP, CAPTURE} state_t;
    state_t state_q;
    logic irq_en_q, done_q, overrun_q, dp_load_q, dp_step_q;
    logic [ITER_W-1:0] iter_q;
    logic [DATA_W-1:0] angle_q, cos_q, sin_q;
    logic [31:0] opcount_q;
    logic wr, busy, start, last, unused_read;
    assign wr          = bus.chipselect & bus.write;
    assign busy        = state_q != IDLE;
    assign start       = wr && bus.address == 3'd0 && bus.writedata[0];
    assign last        = iter_q == ITER_W'(ITERATIONS - 1);
    assign unused_read = bus.read;
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            dp_load_q <= 1'b0;
            dp_step_q <= 1'b0;
            iter_q    <= '0;
            angle_q   <= '0;
            cos_q     <= '0;
            sin_q     <= '0;
            opcount_q <= '0;
        end else begin
            dp_load_q <= 1'b0;
            if (wr && bus.address == 3'd0) irq_en_q <= bus.writedata[1];
            if (wr && bus.address == 3'd2) angle_q <= bus.writedata[DATA_W-1:0];
            if (wr && bus.address == 3'd1 && bus.writedata[1]) done_q <= 1'b0;
            if (wr && bus.address == 3'd1 && bus.writedata[2]) overrun_q <= 1'b0;
            if (start && busy) overrun_q <= 1'b1;
            // done set in CAPTURE is placed last so it beats a same-cycle W1C
            case (state_q)
                IDLE: if (start) begin
                    state_q   <= LOAD;
                    dp_load_q <= 1'b1;
                    done_q    <= 1'b0;
                end
                LOAD: begin
                    state_q   <= STEP;
                    dp_step_q <= 1'b1;
                    iter_q    <= '0;
                end
                STEP: if (last) begin
                    state_q   <= CAPTURE;
                    dp_step_q <= 1'b0;
                    iter_q    <= '0;
                end else begin
                    iter_q <= iter_q + ITER_W'(1);
                end
                CAPTURE: begin
                    state_q   <= IDLE;
                    cos_q     <= dp_x;
                    sin_q     <= dp_y;
                    opcount_q <= opcount_q + 32'd1;
                    done_q    <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.readdata = bus.address == 3'd0 ? {30'd0, irq_en_q, 1'b0} :
                          bus.address == 3'd1 ? {29'd0, overrun_q, done_q, busy} :
                          bus.address == 3'd2 ? 32'(angle_q) :
                          bus.address == 3'd3 ? 32'(cos_q) :
                          bus.address == 3'd4 ? 32'(sin_q) :
                          bus.address == 3'd5 ? opcount_q : 32'd0;
    assign irq      = done_q & irq_en_q;
    assign dp_load  = dp_load_q;
    assign dp_angle = angle_q;
    assign dp_step  = dp_step_q;
    assign dp_iter  = iter_q;
endmodule

// File: tb/tb_nios2_cordic_ctrl.sv
// tb_nios2_cordic_ctrl: directed test-plan sequences plus random bus traffic against a cycle-timestamp reference model.
module tb_nios2_cordic_ctrl;
    localparam int N = 16;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic irq, dp_load, dp_step;
    logic [31:0] dp_angle, dp_x, dp_y;
    logic [4:0] dp_iter;
    always #5 clock = ~clock;
    nios2_cordic_ctrl_if bus();
    nios2_cordic_ctrl #(.DATA_W(32), .ITERATIONS(N), .ITER_W(5)) dut (
        .clock(clock), .reset(reset), .bus(bus), .irq(irq), .dp_load(dp_load),
        .dp_angle(dp_angle), .dp_step(dp_step), .dp_iter(dp_iter), .dp_x(dp_x), .dp_y(dp_y)
    );
    int checks = 0, failures = 0;
    // model: operation timing is derived from the cycle number t0 of the accepted start write
    int c = 0, t0 = -1;
    logic [31:0] m_angle, m_cos, m_sin, m_opc;
    logic m_done, m_ovr, m_irqen;
    bit rand_dp = 0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, c);
        end
    endtask
    function automatic bit in_op(int lo, int hi);
        return t0 >= 0 && c >= t0 + lo && c <= t0 + hi;
    endfunction
    function automatic logic [31:0] exp_read(logic [2:0] a, bit busy);
        case (a)
            3'd0: return {30'd0, m_irqen, 1'b0};
            3'd1: return {29'd0, m_ovr, m_done, busy};
            3'd2: return m_angle;
            3'd3: return m_cos;
            3'd4: return m_sin;
            3'd5: return m_opc;
            default: return 32'd0;
        endcase
    endfunction
    task automatic cyc(input logic [2:0] a, input bit cs, input bit rd, input bit wr, input logic [31:0] wd);
        bit busy, cap;
        @(negedge clock);
        reset = 1'b0;
        bus.address = a;
        bus.chipselect = cs;
        bus.read = rd;
        bus.write = wr;
        bus.writedata = wd;
        if (rand_dp) begin
            dp_x = $urandom;
            dp_y = $urandom;
        end
        #1;
        busy = in_op(1, N + 2);
        cap = in_op(N + 2, N + 2);
        check("dp_load", dp_load, in_op(1, 1));
        check("dp_step", dp_step, in_op(2, N + 1));
        check("dp_iter", dp_iter, in_op(2, N + 1) ? c - t0 - 2 : 0);
        check("dp_angle", dp_angle, m_angle);
        check("irq", irq, m_done & m_irqen);
        if (cs && rd) check($sformatf("read%0d", a), bus.readdata, exp_read(a, busy));
        if (cs && wr) begin
            case (a)
                3'd0: begin
                    m_irqen = wd[1];
                    if (wd[0]) begin
                        if (busy) m_ovr = 1'b1;
                        else begin
                            t0 = c;
                            m_done = 1'b0;
                        end
                    end
                end
                3'd1: begin
                    if (wd[1]) m_done = 1'b0;
                    if (wd[2]) m_ovr = 1'b0;
                end
                3'd2: m_angle = wd;
                default: ;
            endcase
        end
        if (cap) begin
            m_cos = dp_x;
            m_sin = dp_y;
            m_opc = m_opc + 32'd1;
            m_done = 1'b1;
        end
        c++;
    endtask
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.chipselect = 1'b0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        t0 = -1;
        {m_angle, m_cos, m_sin, m_opc} = '0;
        {m_done, m_ovr, m_irqen} = '0;
        c++;
    endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cyc(a, 1, 0, 1, d);
    endtask
    task automatic rd(input logic [2:0] a);
        cyc(a, 1, 1, 0, 32'd0);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) rd(3'd1);
    endtask
    initial begin
        bus.address = '0;
        bus.chipselect = 1'b0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.writedata = '0;
        dp_x = 32'h1111;
        dp_y = 32'h2222;
        do_reset();
        rd(0); rd(1); rd(3); rd(5);
        wr(2, 32'h2000_0000); wr(0, 32'h1); idle(18); rd(3); rd(4); rd(5);
        wr(0, 32'h3); idle(19); wr(1, 32'h2); rd(1); rd(0);
        wr(0, 32'h1); idle(4); wr(0, 32'h1); idle(15); rd(1); wr(1, 32'h4); rd(1);
        wr(0, 32'h1); idle(5); wr(2, 32'hAAAA); idle(14); wr(0, 32'h1); idle(19);
        wr(0, 32'h1); idle(7); do_reset(); rd(1); rd(3); rd(4); rd(5); rd(0);
        wr(0, 32'h1); idle(19); rd(5);
        dp_x = 32'h3333;
        dp_y = 32'h4444;
        wr(0, 32'h1); idle(17); wr(1, 32'h2); rd(1); rd(3); rd(4);
        force dut.opcount_q = 32'hFFFF_FFFF;
        m_opc = 32'hFFFF_FFFF;
        rd(5);
        release dut.opcount_q;
        rd(5);
        wr(0, 32'h1); idle(19); rd(5);
        rd(6); rd(7); wr(6, 32'hFFFF_FFFF); wr(7, 32'hFFFF_FFFF); rd(6); rd(7);
        cyc(2, 0, 0, 1, 32'hDEAD_BEEF); cyc(0, 0, 0, 1, 32'h3); cyc(1, 0, 0, 1, 32'h6);
        rd(2); rd(0); rd(1);
        rand_dp = 1;
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] a;
            a = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) a = 3'd0;
            if ($urandom_range(0, 249) == 0) do_reset();
            else cyc(a, $urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 2) == 0, $urandom);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
